mux_4to1_rr: RTL

MUX_4TO1_RR -- requirements
Module: mux_4to1_rr

---
 rtl/mux_4to1_rr.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mux_4to1_rr.sv
// mux_4to1_rr: four-channel round-robin merge into a one-entry registered
// output stage with valid/ready handshakes on every side.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   i_data0..3   per-channel payload (WIDTH)
//   i_valid[3:0] channel n offers a word
//   i_ready[3:0] channel n word accepted this cycle (one-hot or zero)
//   y            registered merged payload (WIDTH)
//   y_sel        source channel of y
//   y_valid      y/y_sel hold a word
//   y_ready      downstream accepts y this cycle
//   xfer_cnt     completed output transfers (CNT_W)
//
// Build option: define MUX_4TO1_RR_XFER_CNT_EN to build the wrapping output
// transfer counter; otherwise xfer_cnt is tied to zero.
//
// state | meaning
// EMPTY | output register holds no word (y_valid=0)
// FULL  | output register holds a word for downstream (y_valid=1)

module mux_4to1_rr #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic [WIDTH-1:0] i_data3,
    input  logic [3:0]       i_valid,
    output logic [3:0]       i_ready,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       y_sel,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [1:0]       y_sel_q, y_sel_d;
    logic [1:0]       ptr_q, ptr_d;

    logic             load;
    logic             grant_vld;
    logic [1:0]       grant;
    logic [1:0]       cand;
    logic [WIDTH-1:0] grant_data;

    assign y_valid = (state_q == FULL);
    assign y       = y_q;
    assign y_sel   = y_sel_q;
    assign load    = !y_valid || y_ready;

    // Search ptr+1 .. ptr+4 (mod 4). Walking from the far end backwards lets
    // the nearest requesting channel win the last assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant     = ptr_q;
        cand      = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr_q + k[1:0];
            if (i_valid[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        grant_data = i_data0;
        case (grant)
            2'd0:    grant_data = i_data0;
            2'd1:    grant_data = i_data1;
            2'd2:    grant_data = i_data2;
            default: grant_data = i_data3;
        endcase
    end

    // Reset must suppress acceptance, since the word would be lost anyway.
    always_comb begin
        i_ready = 4'b0000;
        if (!rst && load && grant_vld) begin
            i_ready = 4'b0001 << grant;
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        y_sel_d = y_sel_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (grant_vld) begin
                state_d = FULL;
                y_d     = grant_data;
                y_sel_d = grant;
                ptr_d   = grant;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            y_q     <= '0;
            y_sel_q <= 2'd0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            y_sel_q <= y_sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MUX_4TO1_RR_XFER_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (y_valid && y_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign xfer_cnt = cnt_q;
`else
    assign xfer_cnt = '0;
`endif

endmodule
